// File: rtl/lvds_tx_mem_streamer_pkg.sv
// -----------------------------------------------------------------------------
// lvds_tx_mem_streamer_pkg
// Shared constants for the on-chip-RAM to LVDS nibble streamer:
//   - nibbles-per-word constant and helper
//   - FSM state encoding (IDLE / RUN / FINISH)
//   - Avalon-MM tie-off values for the read-only RAM master
// -----------------------------------------------------------------------------
package lvds_tx_mem_streamer_pkg;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_NIB_W     = 4;
    localparam int unsigned NIBS_PER_WORD = DEF_DATA_W / DEF_NIB_W;

    // FSM state encoding, kept as plain constants for legacy tools
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_FINISH = 2'd2;

    // The streamer only ever reads the RAM
    localparam logic       MEM_WRITE_TIE  = 1'b0;
    localparam logic [3:0] MEM_BYTEEN_TIE = 4'hF;
    localparam logic       MEM_CLKEN_TIE  = 1'b1;

    function automatic int unsigned nibs_per_word(input int unsigned data_w,
                                                  input int unsigned nib_w);
        return data_w / nib_w;
    endfunction

endpackage

// File: rtl/lvds_word_serializer.sv
// -----------------------------------------------------------------------------
// lvds_word_serializer
// Two-deep word buffer (shift register SR + prefetch register PB) that emits
// each word as NIB_W-bit nibbles, least-significant first, on a valid/ready
// stream.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   flush           drop both buffered words (abort)
//   load_valid      a RAM word is presented on load_data this cycle
//   load_data       word to buffer
//   can_accept      PB is free, so a newly issued read has a slot to land in
//   empty_next      both buffers will be empty after this edge
//   tx_data         current nibble (0 when nothing is held)
//   tx_valid        SR holds a word
//   tx_ready        consumer accepts the nibble
// -----------------------------------------------------------------------------
module lvds_word_serializer
    import lvds_tx_mem_streamer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NIB_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              can_accept,
    output logic              empty_next,
    output logic [NIB_W-1:0]  tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int NIBS  = int'(nibs_per_word(DATA_W, NIB_W));
    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;

    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] pb;
    logic              sr_full;
    logic              pb_full;
    logic [IDX_W-1:0]  idx;

    logic              xfer;
    logic              sr_free;
    logic [NIB_W-1:0]  nib;

    assign xfer    = sr_full && tx_ready;
    // SR may take a new word at this edge: already empty, or its last nibble leaves now
    assign sr_free = !sr_full || (xfer && (idx == IDX_W'(NIBS - 1)));

    // PB only fills while SR is full, so an empty PB always means a free slot
    assign can_accept = !pb_full;
    assign empty_next = sr_free && !pb_full && !load_valid;

    always_comb begin
        nib = '0;
        for (int i = 0; i < NIBS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib = sr[i*NIB_W +: NIB_W];
            end
        end
    end

    assign tx_valid = sr_full;
    assign tx_data  = sr_full ? nib : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_full <= 1'b0;
            pb_full <= 1'b0;
            idx     <= '0;
        end else if (flush) begin
            sr_full <= 1'b0;
            pb_full <= 1'b0;
            idx     <= '0;
        end else if (sr_free) begin
            idx <= '0;
            if (pb_full) begin
                sr_full <= 1'b1;
                pb_full <= load_valid;
            end else begin
                sr_full <= load_valid;
            end
        end else begin
            if (xfer) begin
                idx <= idx + IDX_W'(1);
            end
            if (load_valid) begin
                pb_full <= 1'b1;
            end
        end
    end

    // Word storage carries no reset; the full flags qualify it
    always_ff @(posedge clk) begin
        if (sr_free) begin
            if (pb_full) begin
                sr <= pb;
                if (load_valid) begin
                    pb <= load_data;
                end
            end else if (load_valid) begin
                sr <= load_data;
            end
        end else if (load_valid) begin
            pb <= load_data;
        end
    end

endmodule

// File: rtl/lvds_tx_mem_streamer.sv
// -----------------------------------------------------------------------------
// lvds_tx_mem_streamer
// Reads word_count words from the on-chip RAM starting at base_addr and
// streams them, least-significant nibble first, to the 4-lane LVDS
// transmitter. One read outstanding at most; a prefetch word keeps the
// stream gap-free while tx_ready stays high.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, abort               launch (when idle) / cancel a transfer
//   base_addr, word_count      transfer descriptor, sampled at start
//   busy, done                 transfer active / one-cycle end pulse
//   mem_*                      Avalon-MM master to the RAM (read-only)
//   tx_data, tx_valid, tx_ready nibble stream to the LVDS transmitter
// -----------------------------------------------------------------------------
module lvds_tx_mem_streamer
    import lvds_tx_mem_streamer_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int NIB_W  = 4,
    parameter int CNT_W  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [NIB_W-1:0]  tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  rem_rd;
    logic              rd_pending;
    logic              rd_issue;
    logic              st_idle;
    logic              st_run;
    logic              ser_can_accept;
    logic              ser_empty_next;

    assign st_idle = (state == ST_IDLE);
    assign st_run  = (state == ST_RUN);
    assign busy    = !st_idle;
    assign done    = (state == ST_FINISH);

    // The first read goes out in the start cycle itself, straight from base_addr,
    // so the first nibble is on the stream two cycles after start.
    always_comb begin
        rd_issue = 1'b0;
        if (st_idle) begin
            rd_issue = start && (word_count != '0);
        end else if (st_run) begin
            rd_issue = !abort && (rem_rd != '0) && !rd_pending && ser_can_accept;
        end
    end

    assign mem_chipselect = rd_issue;
    assign mem_address    = !rd_issue ? '0 : (st_idle ? base_addr : ptr);
    assign mem_write      = MEM_WRITE_TIE;
    assign mem_byteenable = MEM_BYTEEN_TIE;
    assign mem_clken      = MEM_CLKEN_TIE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            rem_rd     <= '0;
            rd_pending <= 1'b0;
        end else begin
            // An abort suppresses issue, so this also forgets any in-flight read
            rd_pending <= rd_issue;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            ptr    <= base_addr + ADDR_W'(1);
                            rem_rd <= word_count - CNT_W'(1);
                            state  <= ST_RUN;
                        end else begin
                            rem_rd <= '0;
                            state  <= ST_FINISH;
                        end
                    end
                end
                ST_RUN: begin
                    if (rd_issue) begin
                        ptr    <= ptr + ADDR_W'(1);
                        rem_rd <= rem_rd - CNT_W'(1);
                    end
                    // Look ahead at the buffers so done follows the last nibble directly
                    if (abort) begin
                        state <= ST_FINISH;
                    end else if ((rem_rd == '0) && !rd_pending && ser_empty_next) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    lvds_word_serializer #(
        .DATA_W (DATA_W),
        .NIB_W  (NIB_W)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .flush      (abort && !st_idle),
        .load_valid (rd_pending),
        .load_data  (mem_readdata),
        .can_accept (ser_can_accept),
        .empty_next (ser_empty_next),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

endmodule

// File: tb/tb_lvds_tx_mem_streamer.sv
// -----------------------------------------------------------------------------
// tb_lvds_tx_mem_streamer
// Directed bench for lvds_tx_mem_streamer with a behavioural one-cycle RAM.
// -----------------------------------------------------------------------------
module tb_lvds_tx_mem_streamer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [12:0] base_addr = '0;
    logic [13:0] word_count = '0;
    logic        busy, done;
    logic [12:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic [3:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;

    logic [31:0] mem [0:8191];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [3:0] nib_q[$];
    int         addr_q[$];
    int cs_cnt, cs_prev, done_cnt, done_cyc, start_cyc, first_vld_cyc, last_vld_cyc;
    int vld_cycles, last_xfer_cyc, stall_err, occ_err, words_done, nib_in_word, occ;
    logic       stalled_prev;
    logic [3:0] stalled_data;

    logic       bp_mode = 1'b0;
    logic [3:0] pat = 4'b1001;
    int         ph = 0;

    lvds_tx_mem_streamer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem[mem_address];
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // tx_ready: held high, or cycling 1,0,0,1 during the backpressure test
    initial forever begin
        @(posedge clk);
        #1;
        if (bp_mode) begin
            tx_ready = pat[ph];
            ph = (ph + 1) % 4;
        end else begin
            tx_ready = 1'b1;
        end
    end

    // Observer: records the stream, reads and done pulses each cycle
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            occ = (cs_cnt - cs_prev) - words_done;
            if (occ > 2) occ_err++;
            if (mem_chipselect && (occ >= 2 || cs_prev != 0)) occ_err++;
            if (start && !busy) start_cyc = cyc;
            if (stalled_prev && (!tx_valid || tx_data !== stalled_data)) stall_err++;
            stalled_prev = tx_valid && !tx_ready;
            stalled_data = tx_data;
            if (tx_valid) begin
                vld_cycles++;
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                last_vld_cyc = cyc;
            end
            if (tx_valid && tx_ready) begin
                nib_q.push_back(tx_data);
                last_xfer_cyc = cyc;
                nib_in_word++;
                if (nib_in_word == 8) begin
                    nib_in_word = 0;
                    words_done++;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            cs_prev = mem_chipselect ? 1 : 0;
            if (mem_chipselect) begin
                cs_cnt++;
                addr_q.push_back(int'(mem_address));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    function automatic logic [3:0] nib_at(input int i);
        return (i < nib_q.size()) ? nib_q[i] : 4'hx;
    endfunction

    function automatic int addr_at(input int i);
        return (i < addr_q.size()) ? addr_q[i] : -1;
    endfunction

    function automatic logic [3:0] exp_nib(input int waddr, input int k);
        logic [31:0] w;
        w = mem[waddr % 8192];
        return w[k*4 +: 4];
    endfunction

    task automatic clear_mon();
        nib_q.delete();
        addr_q.delete();
        cs_cnt = 0; cs_prev = 0; done_cnt = 0; done_cyc = -1; start_cyc = -1;
        first_vld_cyc = -1; last_vld_cyc = -1; vld_cycles = 0; last_xfer_cyc = -1;
        stall_err = 0; occ_err = 0; words_done = 0; nib_in_word = 0; stalled_prev = 1'b0;
    endtask

    task automatic launch(input logic [12:0] b, input logic [13:0] c);
        @(posedge clk); #1;
        base_addr = b;
        word_count = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n0;
        int k;
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (done_cnt == n0) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_stream(input string tag, input int waddr, input int nwords);
        chk({tag, "_nib_count"}, nib_q.size(), nwords * 8);
        for (int w = 0; w < nwords; w++) begin
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("%s_w%0d_n%0d", tag, w, k), nib_at(w*8 + k), exp_nib(waddr + w, k));
            end
        end
    endtask

    initial begin
        logic [31:0] word;
        int k;
        for (int i = 0; i < 8192; i++) mem[i] = {i[15:0] ^ 16'hC3A5, 16'(i * 7 + 3)};
        mem[0] = 32'h8765_4321;
        clear_mon();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("tie_write", mem_write, 0);
        chk("tie_byteen", mem_byteenable, 4'hF);
        chk("tie_clken", mem_clken, 1);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Basic single-word transfer
        clear_mon();
        launch(13'd0, 14'd1);
        wait_done(40, "basic");
        for (int n = 0; n < 8; n++) chk($sformatf("basic_nib%0d", n), nib_at(n), n + 1);
        chk("basic_nib_count", nib_q.size(), 8);
        chk("basic_first_valid_lat", first_vld_cyc - start_cyc, 2);
        chk("basic_done_after_last", done_cyc - last_xfer_cyc, 1);
        chk("basic_done_pulses", done_cnt, 1);
        chk("basic_busy_after", busy, 0);
        chk("basic_cs_pulses", cs_cnt, 1);

        // Back-to-back words, no gaps
        clear_mon();
        launch(13'd16, 14'd4);
        wait_done(80, "b2b");
        check_stream("b2b", 16, 4);
        chk("b2b_cs_pulses", cs_cnt, 4);
        chk("b2b_valid_cycles", vld_cycles, 32);
        chk("b2b_valid_span", last_vld_cyc - first_vld_cyc, 31);

        // Backpressure
        clear_mon();
        ph = 0;
        bp_mode = 1'b1;
        launch(13'd32, 14'd3);
        wait_done(200, "bp");
        bp_mode = 1'b0;
        check_stream("bp", 32, 3);
        chk("bp_stall_hold", stall_err, 0);
        chk("bp_occupancy", occ_err, 0);
        chk("bp_cs_pulses", cs_cnt, 3);

        // Address wrap-around
        clear_mon();
        launch(13'd8190, 14'd4);
        wait_done(80, "wrap");
        chk("wrap_addr0", addr_at(0), 8190);
        chk("wrap_addr1", addr_at(1), 8191);
        chk("wrap_addr2", addr_at(2), 0);
        chk("wrap_addr3", addr_at(3), 1);
        check_stream("wrap", 8190, 4);

        // Zero count
        clear_mon();
        launch(13'd5, 14'd0);
        wait_done(10, "zero");
        chk("zero_done_within_2", (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1);
        chk("zero_cs_pulses", cs_cnt, 0);
        chk("zero_done_pulses", done_cnt, 1);

        // Start while busy is ignored
        clear_mon();
        launch(13'd40, 14'd2);
        repeat (3) @(posedge clk);
        launch(13'd100, 14'd5);
        wait_done(80, "ign");
        chk("ign_addr0", addr_at(0), 40);
        chk("ign_addr1", addr_at(1), 41);
        chk("ign_cs_pulses", cs_cnt, 2);
        chk("ign_nib_count", nib_q.size(), 16);
        chk("ign_done_pulses", done_cnt, 1);

        // Abort at the 3rd nibble of word 2
        clear_mon();
        launch(13'd48, 14'd3);
        k = 0;
        while (nib_q.size() < 10 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("abort_reach_nib10", nib_q.size(), 10);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_tx_valid_next", tx_valid, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_done_pulses", done_cnt, 1);
        chk("abort_busy", busy, 0);
        chk("abort_nib_count", nib_q.size(), 11);
        clear_mon();
        launch(13'd0, 14'd1);
        wait_done(40, "after_abort");
        word = '0;
        for (int n = 0; n < 8; n++) word[n*4 +: 4] = nib_at(n);
        chk("after_abort_word", word, 32'h8765_4321);
        chk("after_abort_done_pulses", done_cnt, 1);

        // Reset mid-stream
        clear_mon();
        launch(13'd0, 14'd4);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_valid_before_reset", tx_valid, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_cs", mem_chipselect, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_rst_no_done", done_cnt, 0);
        chk("mid_rst_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
